// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues instruction-memory requests, and holds the
// IF/ID register. Branches and jumps take effect after one delay slot.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        shouldStall,
   input  logic        shouldJumpOrBranch,
   input  logic        isJumpIndex,
   input  logic [25:0] jumpIndex,
   input  logic        isJumpRegister,
   input  logic [31:0] registerRsValue,
   output logic        imemRequest,
   output logic [31:0] imemAddress,
   input  logic        imemValid,
   input  logic [31:0] imemData,
   output logic [31:0] instruction,
   output logic [31:0] idPc_4,
   output logic        idValid,
   output logic [31:0] pc
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic        [31:0] r_pc;
   logic        [31:0] r_hold;
   logic        [31:0] r_pend_tgt;
   logic               r_pend_vld;
   logic        [31:0] r_instr_p1;
   logic        [31:0] r_pc4_p1;
   logic               r_vld_p1;

   logic               w_redirect;
   logic               w_deliver;
   logic               w_capture;
   logic        [31:0] w_word;
   logic signed [31:0] w_br_off;
   logic        [31:0] w_target;
   logic        [31:0] w_pc_plus4;
   logic        [31:0] w_pc_nxt;

   // Redirect is only meaningful when ID holds a real instruction and is not stalled.
   assign w_redirect = r_vld_p1 && shouldJumpOrBranch && !shouldStall;
   assign w_capture  = (r_state == S_WAIT) && imemValid && shouldStall;
   assign w_deliver  = !shouldStall &&
                       (((r_state == S_WAIT) && imemValid) || (r_state == S_HOLD));
   assign w_word     = (r_state == S_HOLD) ? r_hold : imemData;

   assign w_br_off   = {{14{r_instr_p1[15]}}, r_instr_p1[15:0], 2'b00};
   assign w_target   = isJumpRegister ? registerRsValue :
                       isJumpIndex    ? {r_pc4_p1[31:28], jumpIndex, 2'b00} :
                                        r_pc4_p1 + $unsigned(w_br_off);
   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_pc_nxt   = w_redirect ? w_target :
                       r_pend_vld ? r_pend_tgt : w_pc_plus4;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: w_state_nxt = S_WAIT;
         S_WAIT: if (w_capture) w_state_nxt = S_HOLD;
         S_HOLD: if (!shouldStall) w_state_nxt = S_WAIT;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // IF/ID boundary: deliver, bubble, or hold under stall.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc       <= RESET_PC;
         r_hold     <= 32'd0;
         r_pend_tgt <= 32'd0;
         r_pend_vld <= 1'b0;
         r_instr_p1 <= 32'd0;
         r_pc4_p1   <= 32'd0;
         r_vld_p1   <= 1'b0;
      end else begin
         if (w_capture) r_hold <= imemData;
         if (w_deliver) begin
            r_instr_p1 <= w_word;
            r_pc4_p1   <= w_pc_plus4;
            r_vld_p1   <= 1'b1;
            r_pc       <= w_pc_nxt;
            r_pend_vld <= 1'b0;
         end else if (!shouldStall) begin
            r_instr_p1 <= 32'd0;
            r_vld_p1   <= 1'b0;
            if (w_redirect) begin
               r_pend_tgt <= w_target;
               r_pend_vld <= 1'b1;
            end
         end
      end
   end

   assign imemRequest = (r_state == S_WAIT);
   assign imemAddress = r_pc;
   assign pc          = r_pc;
   assign instruction = r_instr_p1;
   assign idPc_4      = r_pc4_p1;
   assign idValid     = r_vld_p1;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: sequential fetch, branch/jump
// delay slots, slow memory, stall/hold buffer and mid-fetch reset.
module tb_instruction_fetch_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        shouldStall = 1'b0;
   logic        shouldJumpOrBranch = 1'b0;
   logic        isJumpIndex = 1'b0;
   logic [25:0] jumpIndex = 26'd0;
   logic        isJumpRegister = 1'b0;
   logic [31:0] registerRsValue = 32'd0;
   logic        imemRequest;
   logic [31:0] imemAddress;
   logic        imemValid = 1'b0;
   logic [31:0] imemData;
   logic [31:0] instruction;
   logic [31:0] idPc_4;
   logic        idValid;
   logic [31:0] pc;

   logic        use_beq = 1'b0;
   logic [31:0] data_xor = 32'd0;
   int          total = 0;
   int          bad = 0;

   // Memory returns its address as data, except an optional BEQ (imm 3) at 0x8.
   assign imemData = (use_beq && imemAddress == 32'h8) ? 32'h1000_0003
                                                      : (imemAddress ^ data_xor);

   instruction_fetch_unit dut (
      .clock(clock), .reset(reset), .shouldStall(shouldStall),
      .shouldJumpOrBranch(shouldJumpOrBranch), .isJumpIndex(isJumpIndex),
      .jumpIndex(jumpIndex), .isJumpRegister(isJumpRegister),
      .registerRsValue(registerRsValue), .imemRequest(imemRequest),
      .imemAddress(imemAddress), .imemValid(imemValid), .imemData(imemData),
      .instruction(instruction), .idPc_4(idPc_4), .idValid(idValid), .pc(pc)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      shouldStall = 1'b0; shouldJumpOrBranch = 1'b0; isJumpIndex = 1'b0;
      isJumpRegister = 1'b0; use_beq = 1'b0; data_xor = 32'd0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      imemValid = 1'b1;
      do_reset();
      total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h0); end
      total++; if (imemRequest !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imemRequest); end
      total++; if ({idValid, instruction, idPc_4} !== 65'd0) begin bad++; $display("FAIL rst_ifid got=%b %h %h exp=0 0 0", idValid, instruction, idPc_4); end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_a [3];
      exp_a = '{32'h0, 32'h4, 32'h8};
      imemValid = 1'b1;
      do_reset();
      tick();
      total++; if (imemRequest !== 1'b1 || idValid !== 1'b0) begin bad++; $display("FAIL seq_first_req got=%b/%b exp=1/0", imemRequest, idValid); end
      for (int i = 0; i < 3; i++) begin
         total++; if (imemAddress !== exp_a[i]) begin bad++; $display("FAIL seq_addr%0d got=%h exp=%h", i, imemAddress, exp_a[i]); end
         tick();
         total++; if (instruction !== exp_a[i] || idPc_4 !== exp_a[i] + 32'd4 || idValid !== 1'b1) begin
            bad++; $display("FAIL seq_ifid%0d got=%h/%h/%b exp=%h/%h/1", i, instruction, idPc_4, idValid, exp_a[i], exp_a[i] + 32'd4);
         end
      end
   endtask

   task automatic test_branch();
      imemValid = 1'b1;
      do_reset();
      use_beq = 1'b1;
      tick(); tick(); tick(); tick();
      total++; if (instruction !== 32'h1000_0003 || idPc_4 !== 32'hC || imemAddress !== 32'hC) begin
         bad++; $display("FAIL beq_in_id got=%h/%h/%h exp=10000003/0000000c/0000000c", instruction, idPc_4, imemAddress);
      end
      shouldJumpOrBranch = 1'b1;
      tick();
      shouldJumpOrBranch = 1'b0;
      total++; if (instruction !== 32'hC || idValid !== 1'b1) begin bad++; $display("FAIL beq_slot got=%h/%b exp=0000000c/1", instruction, idValid); end
      total++; if (imemAddress !== 32'h18) begin bad++; $display("FAIL beq_target got=%h exp=00000018", imemAddress); end
      tick();
      total++; if (instruction !== 32'h18 || idPc_4 !== 32'h1C) begin bad++; $display("FAIL beq_after got=%h/%h exp=00000018/0000001c", instruction, idPc_4); end
   endtask

   task automatic test_jump();
      imemValid = 1'b1;
      do_reset();
      tick(); tick();
      shouldJumpOrBranch = 1'b1; isJumpIndex = 1'b1; jumpIndex = 26'h40;
      tick();
      total++; if (imemAddress !== 32'h100 || instruction !== 32'h4) begin bad++; $display("FAIL j_target got=%h/%h exp=00000100/00000004", imemAddress, instruction); end
      isJumpRegister = 1'b1; registerRsValue = 32'h200;
      tick();
      shouldJumpOrBranch = 1'b0; isJumpIndex = 1'b0; isJumpRegister = 1'b0;
      total++; if (imemAddress !== 32'h200 || instruction !== 32'h100) begin bad++; $display("FAIL jr_target got=%h/%h exp=00000200/00000100", imemAddress, instruction); end
   endtask

   task automatic test_slow_memory();
      imemValid = 1'b0;
      do_reset();
      tick(); tick(); tick();
      total++; if (idValid !== 1'b0 || imemAddress !== 32'h0 || imemRequest !== 1'b1) begin bad++; $display("FAIL slow_wait got=%b/%h/%b exp=0/00000000/1", idValid, imemAddress, imemRequest); end
      imemValid = 1'b1;
      tick();
      imemValid = 1'b0;
      total++; if (instruction !== 32'h0 || idValid !== 1'b1 || idPc_4 !== 32'h4) begin bad++; $display("FAIL slow_first got=%h/%b/%h exp=00000000/1/00000004", instruction, idValid, idPc_4); end
      shouldJumpOrBranch = 1'b1; isJumpIndex = 1'b1; jumpIndex = 26'h40;
      tick();
      shouldJumpOrBranch = 1'b0; isJumpIndex = 1'b0;
      total++; if (idValid !== 1'b0 || instruction !== 32'h0 || idPc_4 !== 32'h4 || imemAddress !== 32'h4) begin
         bad++; $display("FAIL slow_bubble got=%b/%h/%h/%h exp=0/00000000/00000004/00000004", idValid, instruction, idPc_4, imemAddress);
      end
      tick();
      total++; if (idValid !== 1'b0 || imemAddress !== 32'h4) begin bad++; $display("FAIL slow_bubble2 got=%b/%h exp=0/00000004", idValid, imemAddress); end
      imemValid = 1'b1;
      tick();
      imemValid = 1'b0;
      total++; if (instruction !== 32'h4 || idValid !== 1'b1 || idPc_4 !== 32'h8) begin bad++; $display("FAIL slow_slot got=%h/%b/%h exp=00000004/1/00000008", instruction, idValid, idPc_4); end
      total++; if (pc !== 32'h100) begin bad++; $display("FAIL slow_target got=%h exp=00000100", pc); end
   endtask

   task automatic test_stall();
      imemValid = 1'b1;
      do_reset();
      tick(); tick();
      shouldStall = 1'b1;
      tick();
      data_xor = 32'hFFFF_0000;
      for (int i = 0; i < 2; i++) begin
         total++; if (imemRequest !== 1'b0 || pc !== 32'h4) begin bad++; $display("FAIL stall_hold%0d got=%b/%h exp=0/00000004", i, imemRequest, pc); end
         total++; if (instruction !== 32'h0 || idPc_4 !== 32'h4 || idValid !== 1'b1) begin
            bad++; $display("FAIL stall_ifid%0d got=%h/%h/%b exp=00000000/00000004/1", i, instruction, idPc_4, idValid);
         end
         if (i == 0) tick();
      end
      shouldStall = 1'b0;
      tick();
      data_xor = 32'd0;
      total++; if (instruction !== 32'h4 || idPc_4 !== 32'h8 || idValid !== 1'b1) begin bad++; $display("FAIL stall_release got=%h/%h/%b exp=00000004/00000008/1", instruction, idPc_4, idValid); end
      total++; if (imemRequest !== 1'b1 || imemAddress !== 32'h8) begin bad++; $display("FAIL stall_next_req got=%b/%h exp=1/00000008", imemRequest, imemAddress); end
   endtask

   task automatic test_reset_midfetch();
      imemValid = 1'b1;
      do_reset();
      tick(); tick(); tick();
      imemValid = 1'b0;
      tick();
      total++; if (imemAddress !== 32'h8 || imemRequest !== 1'b1) begin bad++; $display("FAIL mid_wait got=%h/%b exp=00000008/1", imemAddress, imemRequest); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      imemValid = 1'b1;
      total++; if (pc !== 32'h0 || idValid !== 1'b0 || imemRequest !== 1'b0) begin bad++; $display("FAIL mid_reset got=%h/%b/%b exp=00000000/0/0", pc, idValid, imemRequest); end
      tick();
      total++; if (idValid !== 1'b0 || imemAddress !== 32'h0 || imemRequest !== 1'b1) begin bad++; $display("FAIL mid_idle_ignore got=%b/%h/%b exp=0/00000000/1", idValid, imemAddress, imemRequest); end
      tick();
      total++; if (instruction !== 32'h0 || idPc_4 !== 32'h4 || idValid !== 1'b1) begin bad++; $display("FAIL mid_resume got=%h/%h/%b exp=00000000/00000004/1", instruction, idPc_4, idValid); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_jump();
      test_slow_memory();
      test_stall();
      test_reset_midfetch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
